// File: rtl/struct74_pkg.sv
// Shared definitions for the struct74 parametrised parts library.
package struct74_pkg;

  // 3-bit function select shared by the struct74 registered parts
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHR  = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_INC  = 3'd4,
    MODE_DEC  = 3'd5,
    MODE_ROR  = 3'd6,
    MODE_ROL  = 3'd7
  } mode_t;

endpackage

// File: rtl/usr_next.sv
// Next-state and terminal-count logic for the universal shift/count register.
module usr_next
  import struct74_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q_next,
  output logic             tc
);

  mode_t m;
  assign m = mode_t'(mode);

  // Clear beats enable, enable beats the mode function
  always_comb begin
    q_next = q;
    if (!clr_n) begin
      q_next = '0;
    end else if (en) begin
      case (m)
        MODE_HOLD: q_next = q;
        MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
        MODE_LOAD: q_next = d;
        MODE_INC:  q_next = q + 1'b1;
        MODE_DEC:  q_next = q - 1'b1;
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        default:   q_next = q;
      endcase
    end
  end

  // Ripple-carry style terminal count for cascading the next stage
  always_comb begin
    tc = 1'b0;
    if (en) begin
      if ((m == MODE_INC) && (q == '1)) tc = 1'b1;
      if ((m == MODE_DEC) && (q == '0)) tc = 1'b1;
    end
  end

endmodule

// File: rtl/univ_shiftreg.sv
// WIDTH-bit universal shift/count register (74194 + 74163 generalisation).
module univ_shiftreg
  import struct74_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             tc
);

  logic [WIDTH-1:0] q_next;

  usr_next #(.WIDTH(WIDTH)) u_next (
    .mode   (mode),
    .en     (en),
    .clr_n  (clr_n),
    .q      (q),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .q_next (q_next),
    .tc     (tc)
  );

  // The register itself; asynchronous reset to RESET_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VAL;
    else        q <= q_next;
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule
